// File: rtl/fighter_pkg.sv
// Shared types and default tables for the two-player attack engine.
// Attack tables are indexed by attack id (0 = punch, 1 = kick).
package fighter_pkg;

    typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN} atk_state_t;

    localparam int NUM_ATK   = 2;
    localparam int ID_W      = (NUM_ATK > 1) ? $clog2(NUM_ATK) : 1;
    localparam int ATK_PUNCH = 0;
    localparam int ATK_KICK  = 1;

    localparam logic [NUM_ATK-1:0][7:0] KEY_P1 = {8'h07, 8'h06};
    localparam logic [NUM_ATK-1:0][7:0] KEY_P2 = {8'h12, 8'h11};

    localparam int RANGE [NUM_ATK] = '{135, 160};
    localparam int YOFF  [NUM_ATK] = '{30, 60};

    localparam int STARTUP_LEN  = 3;
    localparam int ACTIVE_LEN   = 4;
    localparam int RECOVERY_LEN = 6;
    localparam int HITSTUN_LEN  = 12;
    localparam int KB_HIT       = 8;
    localparam int KB_BLOCK     = 3;

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack sequencer: key edge detect, state/counter, landed flag,
// registered hit/block pulses and decaying knockback.
module attack_fsm
    import fighter_pkg::*;
(
    input  logic                     frame_clk,
    input  logic                     Reset_n,
    input  logic [3:0][7:0]          keys,
    input  logic [NUM_ATK-1:0][7:0]  key_tab,
    input  logic                     got_hit,
    input  logic                     got_block,
    input  logic                     did_connect,
    input  int                       kb_new,
    output atk_state_t               state,
    output logic [ID_W-1:0]          atk_id,
    output logic                     landed,
    output logic                     hit,
    output logic                     block,
    output int                       knockback
);

    atk_state_t           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ID_W-1:0]      id_q, id_d, pick;
    logic [NUM_ATK-1:0]   key_q, key_d, key_rise;
    logic                 landed_q, landed_d, hit_q, hit_d, block_q, block_d;
    int                   kb_q, kb_d;

    always_comb begin
        key_d = '0;
        for (int a = 0; a < NUM_ATK; a++)
            for (int k = 0; k < 4; k++)
                if (keys[k] == key_tab[a]) key_d[a] = 1'b1;
        key_rise = key_d & ~key_q;
        // Descending scan so the lowest rising index wins.
        pick = '0;
        for (int a = NUM_ATK - 1; a >= 0; a--)
            if (key_rise[a]) pick = ID_W'(a);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        id_d     = id_q;
        landed_d = landed_q | did_connect;
        hit_d    = got_hit;
        block_d  = got_block;
        unique case (state_q)
            IDLE: if (|key_rise) begin
                state_d  = STARTUP;
                cnt_d    = 8'(STARTUP_LEN - 1);
                id_d     = pick;
                landed_d = 1'b0;
            end
            STARTUP:  if (cnt_q == 8'd0) begin
                state_d = ACTIVE;
                cnt_d   = 8'(ACTIVE_LEN - 1);
            end
            ACTIVE:   if (cnt_q == 8'd0) begin
                state_d = RECOVERY;
                cnt_d   = 8'(RECOVERY_LEN - 1);
            end
            RECOVERY: if (cnt_q == 8'd0) state_d = IDLE;
            HITSTUN:  if (cnt_q == 8'd0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // A clean hit cancels whatever was in progress, including a running hitstun.
        if (got_hit) begin
            state_d = HITSTUN;
            cnt_d   = 8'(HITSTUN_LEN - 1);
        end
        if (got_hit || got_block) kb_d = kb_new;
        else if (kb_q > 0)        kb_d = kb_q - 1;
        else if (kb_q < 0)        kb_d = kb_q + 1;
        else                      kb_d = 0;
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            id_q     <= '0;
            key_q    <= '0;
            landed_q <= 1'b0;
            hit_q    <= 1'b0;
            block_q  <= 1'b0;
            kb_q     <= 0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            key_q    <= key_d;
            landed_q <= landed_d;
            hit_q    <= hit_d;
            block_q  <= block_d;
            kb_q     <= kb_d;
        end
    end

    assign state     = state_q;
    assign atk_id    = id_q;
    assign landed    = landed_q;
    assign hit       = hit_q;
    assign block     = block_q;
    assign knockback = kb_q;

endmodule

// File: rtl/attack_engine.sv
// Two-player attack resolver: evaluates connects from each ACTIVE attacker,
// arbitrates block vs. hit on the defender, and lets simultaneous connects trade.
module attack_engine
    import fighter_pkg::*;
(
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic [7:0]       keycode_0,
    input  logic [7:0]       keycode_1,
    input  logic [7:0]       keycode_2,
    input  logic [7:0]       keycode_3,
    input  logic             crouchP1,
    input  logic             crouchP2,
    input  int               XDist,
    input  int               P1Xpos,
    input  int               P2Xpos,
    input  int               P1Ypos,
    input  int               P2Ypos,
    output atk_state_t       atk_stateP1,
    output atk_state_t       atk_stateP2,
    output logic [ID_W-1:0]  atk_idP1,
    output logic [ID_W-1:0]  atk_idP2,
    output logic             hitP1,
    output logic             hitP2,
    output logic             blockP1,
    output logic             blockP2,
    output int               KnockbackP1,
    output int               KnockbackP2
);

    logic [3:0][7:0] keys;
    logic            landed1, landed2;
    logic            con1, con2, blk1, blk2, hit1, hit2;
    int              kb1_new, kb2_new, mag1, mag2;

    assign keys = {keycode_3, keycode_2, keycode_1, keycode_0};

    // con1: P1's attack lands on P2; con2: P2's attack lands on P1.
    always_comb begin
        con1 = (atk_stateP1 == ACTIVE) && !landed1 && (XDist < RANGE[atk_idP1])
               && (P1Ypos + YOFF[atk_idP1] > P2Ypos);
        con2 = (atk_stateP2 == ACTIVE) && !landed2 && (XDist < RANGE[atk_idP2])
               && (P2Ypos + YOFF[atk_idP2] > P1Ypos);
        blk2 = con1 && crouchP2 && (atk_stateP2 == IDLE || atk_stateP2 == RECOVERY);
        blk1 = con2 && crouchP1 && (atk_stateP1 == IDLE || atk_stateP1 == RECOVERY);
        hit2 = con1 && !blk2;
        hit1 = con2 && !blk1;
        mag2 = blk2 ? KB_BLOCK : KB_HIT;
        mag1 = blk1 ? KB_BLOCK : KB_HIT;
        kb2_new = (P2Xpos >= P1Xpos) ? mag2 : -mag2;
        kb1_new = (P1Xpos >= P2Xpos) ? mag1 : -mag1;
    end

    attack_fsm u_p1 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keys(keys), .key_tab(KEY_P1),
        .got_hit(hit1), .got_block(blk1), .did_connect(con1), .kb_new(kb1_new),
        .state(atk_stateP1), .atk_id(atk_idP1), .landed(landed1),
        .hit(hitP1), .block(blockP1), .knockback(KnockbackP1)
    );

    attack_fsm u_p2 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keys(keys), .key_tab(KEY_P2),
        .got_hit(hit2), .got_block(blk2), .did_connect(con2), .kb_new(kb2_new),
        .state(atk_stateP2), .atk_id(atk_idP2), .landed(landed2),
        .hit(hitP2), .block(blockP2), .knockback(KnockbackP2)
    );

endmodule

// File: tb/tb_attack_engine.sv
// Scoreboard bench for attack_engine: stimulus queues frame-tagged expectations,
// a negedge monitor pops and compares states, knockback and pulses.
module tb_attack_engine;
    import fighter_pkg::*;

    logic            frame_clk = 1'b0;
    logic            Reset_n   = 1'b0;
    logic [7:0]      keycode_0 = '0, keycode_1 = '0, keycode_2 = '0, keycode_3 = '0;
    logic            crouchP1 = 1'b0, crouchP2 = 1'b0;
    int              XDist = 300, P1Xpos = 100, P2Xpos = 200, P1Ypos = 200, P2Ypos = 200;
    atk_state_t      atk_stateP1, atk_stateP2;
    logic [ID_W-1:0] atk_idP1, atk_idP2;
    logic            hitP1, hitP2, blockP1, blockP2;
    int              KnockbackP1, KnockbackP2;

    attack_engine dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n),
        .keycode_0(keycode_0), .keycode_1(keycode_1), .keycode_2(keycode_2), .keycode_3(keycode_3),
        .crouchP1(crouchP1), .crouchP2(crouchP2), .XDist(XDist),
        .P1Xpos(P1Xpos), .P2Xpos(P2Xpos), .P1Ypos(P1Ypos), .P2Ypos(P2Ypos),
        .atk_stateP1(atk_stateP1), .atk_stateP2(atk_stateP2),
        .atk_idP1(atk_idP1), .atk_idP2(atk_idP2),
        .hitP1(hitP1), .hitP2(hitP2), .blockP1(blockP1), .blockP2(blockP2),
        .KnockbackP1(KnockbackP1), .KnockbackP2(KnockbackP2)
    );

    always #5 frame_clk = ~frame_clk;

    int cyc = 0;
    always @(posedge frame_clk) cyc <= cyc + 1;

    typedef struct { int f; atk_state_t s1; atk_state_t s2; int k1; int k2; int id1; } st_exp_t;
    typedef struct { int f; logic [3:0] p; } ev_exp_t;  // p = {hit1,hit2,blk1,blk2}

    st_exp_t sq[$];
    ev_exp_t eq[$];
    int checks = 0, errors = 0, c0 = 0;

    task automatic exp_st(input int f, input atk_state_t a, input atk_state_t b,
                          input int k1, input int k2, input int id1 = -1);
        st_exp_t e;
        e.f = c0 + f; e.s1 = a; e.s2 = b; e.k1 = k1; e.k2 = k2; e.id1 = id1;
        sq.push_back(e);
    endtask

    task automatic exp_ev(input int f, input logic [3:0] p);
        ev_exp_t e;
        e.f = c0 + f; e.p = p;
        eq.push_back(e);
    endtask

    task automatic next_frame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic run_to(input int f);
        while (cyc < c0 + f) next_frame();
    endtask

    task automatic start_test();
        next_frame();
        c0 = cyc;
    endtask

    always @(negedge frame_clk) begin
        st_exp_t    s;
        ev_exp_t    v;
        logic [3:0] pulses;
        while (sq.size() > 0 && sq[0].f <= cyc) begin
            s = sq.pop_front();
            checks++;
            if (s.f != cyc || atk_stateP1 != s.s1 || atk_stateP2 != s.s2 ||
                KnockbackP1 != s.k1 || KnockbackP2 != s.k2 ||
                (s.id1 >= 0 && int'(atk_idP1) != s.id1)) begin
                errors++;
                $display("FAIL state cyc=%0d: got st=%0d/%0d kb=%0d/%0d id1=%0d, exp f=%0d st=%0d/%0d kb=%0d/%0d id1=%0d",
                         cyc, atk_stateP1, atk_stateP2, KnockbackP1, KnockbackP2, atk_idP1,
                         s.f, s.s1, s.s2, s.k1, s.k2, s.id1);
            end
        end
        pulses = {hitP1, hitP2, blockP1, blockP2};
        while (eq.size() > 0 && eq[0].f < cyc) begin
            v = eq.pop_front();
            checks++; errors++;
            $display("FAIL pulse_missed cyc=%0d: got none, exp pulses=%b at %0d", cyc, v.p, v.f);
        end
        if (eq.size() > 0 && eq[0].f == cyc) begin
            v = eq.pop_front();
            checks++;
            if (pulses != v.p) begin
                errors++;
                $display("FAIL pulse cyc=%0d: got %b exp %b", cyc, pulses, v.p);
            end
        end else if (pulses != 4'b0) begin
            checks++; errors++;
            $display("FAIL pulse_unexpected cyc=%0d: got %b exp 0000", cyc, pulses);
        end
    end

    initial begin
        // Reset state
        start_test();
        exp_st(0, IDLE, IDLE, 0, 0, 0);
        next_frame();
        Reset_n = 1'b1;
        next_frame();

        // Clean punch hit, knockback decay, defender hitstun
        XDist = 100;
        start_test();
        keycode_0 = 8'h06;
        exp_st(1, STARTUP, IDLE, 0, 0, 0);
        exp_st(3, STARTUP, IDLE, 0, 0);
        exp_st(4, ACTIVE, IDLE, 0, 0);
        exp_st(5, ACTIVE, HITSTUN, 0, 8);
        exp_st(6, ACTIVE, HITSTUN, 0, 7);
        exp_st(8, RECOVERY, HITSTUN, 0, 5);
        exp_st(13, RECOVERY, HITSTUN, 0, 0);
        exp_st(14, IDLE, HITSTUN, 0, 0);
        exp_st(16, IDLE, HITSTUN, 0, 0);
        exp_st(17, IDLE, IDLE, 0, 0);
        exp_ev(5, 4'b0100);
        next_frame();
        keycode_0 = 8'h00;
        run_to(20);

        // Held key: one cycle only, no retrigger
        XDist = 300;
        start_test();
        keycode_2 = 8'h06;
        exp_st(1, STARTUP, IDLE, 0, 0);
        exp_st(4, ACTIVE, IDLE, 0, 0);
        exp_st(8, RECOVERY, IDLE, 0, 0);
        exp_st(14, IDLE, IDLE, 0, 0);
        exp_st(29, IDLE, IDLE, 0, 0);
        exp_st(32, IDLE, IDLE, 0, 0);
        run_to(30);
        keycode_2 = 8'h00;
        run_to(34);

        // Crouching idle defender blocks
        XDist = 100; crouchP2 = 1'b1;
        start_test();
        keycode_1 = 8'h06;
        exp_st(5, ACTIVE, IDLE, 0, 3);
        exp_st(6, ACTIVE, IDLE, 0, 2);
        exp_st(8, RECOVERY, IDLE, 0, 0);
        exp_st(14, IDLE, IDLE, 0, 0);
        exp_ev(5, 4'b0001);
        next_frame();
        keycode_1 = 8'h00;
        run_to(18);
        crouchP2 = 1'b0;

        // Trade: both punch on the same frame
        start_test();
        keycode_0 = 8'h06; keycode_3 = 8'h11;
        exp_st(4, ACTIVE, ACTIVE, 0, 0);
        exp_st(5, HITSTUN, HITSTUN, -8, 8);
        exp_st(6, HITSTUN, HITSTUN, -7, 7);
        exp_st(16, HITSTUN, HITSTUN, 0, 0);
        exp_st(17, IDLE, IDLE, 0, 0);
        exp_ev(5, 4'b1100);
        next_frame();
        keycode_0 = 8'h00; keycode_3 = 8'h00;
        run_to(20);

        // Kick reaches XDist=150
        XDist = 150;
        start_test();
        keycode_0 = 8'h07;
        exp_st(4, ACTIVE, IDLE, 0, 0, 1);
        exp_st(5, ACTIVE, HITSTUN, 0, 8, 1);
        exp_st(17, IDLE, IDLE, 0, 0);
        exp_ev(5, 4'b0100);
        next_frame();
        keycode_0 = 8'h00;
        run_to(20);

        // Punch at XDist=150 misses
        start_test();
        keycode_0 = 8'h06;
        exp_st(5, ACTIVE, IDLE, 0, 0, 0);
        exp_st(8, RECOVERY, IDLE, 0, 0);
        exp_st(14, IDLE, IDLE, 0, 0);
        next_frame();
        keycode_0 = 8'h00;
        run_to(16);

        // Punch at XDist=135 is just outside range
        XDist = 135;
        start_test();
        keycode_0 = 8'h06;
        exp_st(5, ACTIVE, IDLE, 0, 0);
        exp_st(14, IDLE, IDLE, 0, 0);
        next_frame();
        keycode_0 = 8'h00;
        run_to(16);

        // Async reset mid-ACTIVE, then a fresh attack
        XDist = 100;
        start_test();
        keycode_0 = 8'h06;
        exp_st(4, IDLE, IDLE, 0, 0, 0);
        exp_st(7, STARTUP, IDLE, 0, 0, 0);
        exp_st(10, ACTIVE, IDLE, 0, 0);
        exp_st(11, ACTIVE, HITSTUN, 0, 8);
        exp_st(23, IDLE, IDLE, 0, 0);
        exp_ev(11, 4'b0100);
        next_frame();
        keycode_0 = 8'h00;
        run_to(4);
        Reset_n = 1'b0;
        next_frame();
        Reset_n = 1'b1;
        next_frame();
        keycode_0 = 8'h06;
        next_frame();
        keycode_0 = 8'h00;
        run_to(26);

        if (sq.size() + eq.size() != 0) begin
            checks += sq.size() + eq.size();
            errors += sq.size() + eq.size();
            $display("FAIL leftover: got %0d unchecked expectations, exp 0", sq.size() + eq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
